// File: rtl/pixel_write_arbiter_if.sv
// Pixel-write request/response bundle between the pixel producers, the
// arbiter, and the screen controller's write port.
interface pixel_write_arbiter_if;
  logic        fb_ready;
  logic [2:0]  req_valid;
  logic [23:0] req_x;
  logic [23:0] req_y;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic [6:0]  pixel_addr_x;
  logic [6:0]  pixel_addr_y;
  logic        pixel_wr_en;
  logic [15:0] pixel_wr_data;
  logic [1:0]  grant_id;
  logic [7:0]  dropped_count;

  modport master (
    output fb_ready, req_valid, req_x, req_y, req_data,
    input  req_ready, pixel_addr_x, pixel_addr_y, pixel_wr_en, pixel_wr_data,
           grant_id, dropped_count
  );

  modport slave (
    input  fb_ready, req_valid, req_x, req_y, req_data,
    output req_ready, pixel_addr_x, pixel_addr_y, pixel_wr_en, pixel_wr_data,
           grant_id, dropped_count
  );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter for three pixel producers in front of the framebuffer
// write port, with coordinate clipping and burst throttling for refresh reads.
module pixel_write_arbiter #(
  parameter int SCREEN_SIZE = 128,
  parameter int MAX_BURST   = 16,
  parameter int GAP_CYCLES  = 2
) (
  input logic                  clk_main,
  input logic                  reset,
  pixel_write_arbiter_if.slave bus
);
  localparam int NUM_REQ = 3;
  localparam logic [7:0] MAX_BURST_B = 8'(MAX_BURST);
  localparam logic [7:0] GAP_B       = 8'(GAP_CYCLES);

  typedef enum logic {ARB, GAP} state_e;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] data;
  } req_t;

  req_t [NUM_REQ-1:0] req;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign req[i] = {bus.req_x[8*i +: 8], bus.req_y[8*i +: 8], bus.req_data[16*i +: 16]};
  end

  state_e      state_q, state_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [7:0]  burst_q, burst_d;
  logic [7:0]  gap_q, gap_d;
  logic [6:0]  addr_x_q, addr_x_d;
  logic [6:0]  addr_y_q, addr_y_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  drop_q, drop_d;

  logic [2:0]  ready;
  logic [1:0]  sel, cand;
  logic        found;
  logic        in_range;

  // Search starts one past the last winner so every producer is served in turn.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    ready = '0;
    if (!reset && state_q == ARB && bus.fb_ready) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = 2'((int'(last_grant_q) + k) % NUM_REQ);
        if (!found && bus.req_valid[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
    if (found) ready = 3'b001 << sel;
  end

  assign in_range = (int'(req[sel].x) < SCREEN_SIZE) && (int'(req[sel].y) < SCREEN_SIZE);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_d      = '0;
    gap_d        = gap_q;
    addr_x_d     = addr_x_q;
    addr_y_d     = addr_y_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    grant_d      = grant_q;
    drop_d       = drop_q;
    case (state_q)
      ARB: begin
        if (found) begin
          last_grant_d = sel;
          grant_d      = sel;
          if (in_range) begin
            wr_en_d   = 1'b1;
            addr_x_d  = req[sel].x[6:0];
            addr_y_d  = req[sel].y[6:0];
            wr_data_d = req[sel].data;
            // A full burst forces a pause so the panel refresh can read.
            if (burst_q == MAX_BURST_B - 8'd1) begin
              state_d = GAP;
              gap_d   = GAP_B;
            end else begin
              burst_d = burst_q + 8'd1;
            end
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q == 8'd1) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state_q      <= ARB;
      last_grant_q <= 2'd2;
      burst_q      <= '0;
      gap_q        <= '0;
      addr_x_q     <= '0;
      addr_y_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      grant_q      <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_q      <= burst_d;
      gap_q        <= gap_d;
      addr_x_q     <= addr_x_d;
      addr_y_q     <= addr_y_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      grant_q      <= grant_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.req_ready     = ready;
  assign bus.pixel_addr_x  = addr_x_q;
  assign bus.pixel_addr_y  = addr_y_q;
  assign bus.pixel_wr_en   = wr_en_q;
  assign bus.pixel_wr_data = wr_data_q;
  assign bus.grant_id      = grant_q;
  assign bus.dropped_count = drop_q;
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Random and directed stimulus against a cycle-level behavioural model of the
// pixel write arbiter, plus literal expectations for the key scenarios.
module tb_pixel_write_arbiter;
  localparam int SCREEN_SIZE = 128;
  localparam int MAX_BURST   = 16;
  localparam int GAP_CYCLES  = 2;

  logic clk_main = 1'b0;
  logic reset    = 1'b1;
  always #5 clk_main = ~clk_main;

  pixel_write_arbiter_if bus();

  pixel_write_arbiter #(
    .SCREEN_SIZE(SCREEN_SIZE),
    .MAX_BURST  (MAX_BURST),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk_main(clk_main),
    .reset   (reset),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: who won last, idle cycles still owed, current write run length.
  int         m_last = 2, m_gap = 0, m_run = 0, m_drop = 0, m_gid = 0;
  bit         m_wen = 1'b0;
  logic [6:0] m_x = '0, m_y = '0;
  logic [15:0] m_d = '0;
  logic [2:0] m_acc = '0;

  function automatic logic [2:0] model_ready();
    logic [2:0] r;
    r = '0;
    if (reset || m_gap > 0 || !bus.fb_ready) return r;
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_last + k) % 3;
      if (bus.req_valid[c]) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  initial begin
    logic [2:0] r;
    logic [7:0] mx, my;
    int i;
    forever begin
      @(negedge clk_main);
      r = model_ready();
      check("req_ready", 64'(bus.req_ready), 64'(r));
      check("pixel_wr_en", 64'(bus.pixel_wr_en), 64'(m_wen));
      check("pixel_addr_x", 64'(bus.pixel_addr_x), 64'(m_x));
      check("pixel_addr_y", 64'(bus.pixel_addr_y), 64'(m_y));
      check("pixel_wr_data", 64'(bus.pixel_wr_data), 64'(m_d));
      check("grant_id", 64'(bus.grant_id), 64'(m_gid));
      check("dropped_count", 64'(bus.dropped_count), 64'(m_drop));
      m_acc = r & bus.req_valid;
      if (reset) begin
        m_last = 2; m_gap = 0; m_run = 0; m_drop = 0; m_gid = 0;
        m_wen = 1'b0; m_x = '0; m_y = '0; m_d = '0; m_acc = '0;
      end else begin
        m_wen = 1'b0;
        if (m_gap > 0) begin
          m_gap--;
          m_run = 0;
        end else if (m_acc != 3'b000) begin
          i = m_acc[0] ? 0 : (m_acc[1] ? 1 : 2);
          m_last = i;
          m_gid  = i;
          mx = bus.req_x[8*i +: 8];
          my = bus.req_y[8*i +: 8];
          if (int'(mx) < SCREEN_SIZE && int'(my) < SCREEN_SIZE) begin
            m_wen = 1'b1;
            m_x = mx[6:0];
            m_y = my[6:0];
            m_d = bus.req_data[16*i +: 16];
            m_run++;
            if (m_run == MAX_BURST) begin
              m_run = 0;
              m_gap = GAP_CYCLES;
            end
          end else begin
            m_run = 0;
            if (m_drop < 255) m_drop++;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input int x, input int y, input int d);
    bus.req_valid[i]          = v;
    bus.req_x[8*i +: 8]       = 8'(x);
    bus.req_y[8*i +: 8]       = 8'(y);
    bus.req_data[16*i +: 16]  = 16'(d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic int rnd_coord();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(128, 255));
    return int'($urandom_range(0, 127));
  endfunction

  initial begin
    int strobes, bad;
    bus.fb_ready  = 1'b1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_data  = '0;
    do_reset();
    check("reset_wr_en", 64'(bus.pixel_wr_en), 64'd0);
    check("reset_dropped", 64'(bus.dropped_count), 64'd0);

    // Single write from requester 1
    set_req(1, 1'b1, 5, 9, 16'hF800);
    #1 check("single_ready", 64'(bus.req_ready), 64'b010);
    tick();
    set_req(1, 1'b0, 5, 9, 16'hF800);
    check("single_wr_en", 64'(bus.pixel_wr_en), 64'd1);
    check("single_xy", 64'({bus.pixel_addr_x, bus.pixel_addr_y}), 64'({7'd5, 7'd9}));
    check("single_data", 64'(bus.pixel_wr_data), 64'hF800);
    check("single_grant", 64'(bus.grant_id), 64'd1);
    tick();
    check("single_strobe_len", 64'(bus.pixel_wr_en), 64'd0);

    // Round robin with all requesters held valid
    do_reset();
    for (int k = 0; k < 3; k++) set_req(k, 1'b1, 10 + k, 20 + k, 16'h1000 + k);
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      #1 check("rr_ready", 64'(bus.req_ready), 64'(3'b001 << (k % 3)));
      tick();
      check("rr_grant", 64'(bus.grant_id), 64'(k % 3));
      strobes += int'(bus.pixel_wr_en);
    end
    bus.req_valid = '0;
    check("rr_strobes", 64'(strobes), 64'd6);

    // Clipping on each axis
    do_reset();
    strobes = 0;
    set_req(0, 1'b1, 128, 3, 16'hAAAA);
    tick();
    strobes += int'(bus.pixel_wr_en);
    set_req(0, 1'b1, 7, 200, 16'h5555);
    tick();
    strobes += int'(bus.pixel_wr_en);
    bus.req_valid = '0;
    tick();
    strobes += int'(bus.pixel_wr_en);
    check("clip_strobes", 64'(strobes), 64'd0);
    check("clip_dropped", 64'(bus.dropped_count), 64'd2);

    // Burst throttle: 16 grants, 2 idle, repeating
    do_reset();
    set_req(2, 1'b1, 33, 44, 16'h07E0);
    strobes = 0;
    bad = 0;
    for (int j = 0; j < 36; j++) begin
      #1 if (bus.req_ready[2] !== ((j % 18) < 16)) bad++;
      tick();
      strobes += int'(bus.pixel_wr_en);
    end
    check("burst_ready_pattern_errs", 64'(bad), 64'd0);
    check("burst_strobes", 64'(strobes), 64'd32);
    bus.req_valid = '0;
    for (int j = 0; j < 4; j++) tick();

    // fb_ready gating, then resume from last_grant+1
    set_req(0, 1'b1, 1, 2, 16'h001F);
    tick();
    bus.req_valid = '0;
    tick();
    bus.fb_ready = 1'b0;
    for (int k = 0; k < 3; k++) set_req(k, 1'b1, 50, 60, 16'hBEEF);
    strobes = 0;
    for (int j = 0; j < 5; j++) begin
      #1 check("gate_ready", 64'(bus.req_ready), 64'd0);
      tick();
      strobes += int'(bus.pixel_wr_en);
    end
    check("gate_strobes", 64'(strobes), 64'd0);
    bus.fb_ready = 1'b1;
    #1 check("gate_resume_ready", 64'(bus.req_ready), 64'b010);

    // Reset while a strobe is in flight
    bus.req_valid = 3'b010;
    tick();
    check("pre_reset_wr_en", 64'(bus.pixel_wr_en), 64'd1);
    reset = 1'b1;
    tick();
    check("reset_cancel_wr_en", 64'(bus.pixel_wr_en), 64'd0);
    check("reset_outputs", 64'({bus.pixel_addr_x, bus.pixel_addr_y, bus.pixel_wr_data, bus.grant_id}), 64'd0);
    reset = 1'b0;
    bus.req_valid = 3'b111;
    #1 check("post_reset_ready", 64'(bus.req_ready), 64'b001);
    tick();
    bus.req_valid = '0;

    // Dropped counter saturation
    do_reset();
    set_req(0, 1'b1, 200, 0, 16'h0);
    for (int j = 0; j < 262; j++) tick();
    check("drop_saturate", 64'(bus.dropped_count), 64'd255);
    bus.req_valid = '0;

    // Random traffic honouring hold-until-accepted
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (m_acc[k] || !bus.req_valid[k]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(k, 1'b1, rnd_coord(), rnd_coord(), int'($urandom_range(0, 65535)));
          else
            bus.req_valid[k] = 1'b0;
        end
      end
      bus.fb_ready = ($urandom_range(0, 9) != 0);
      reset        = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    bus.req_valid = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Shares the screen controller's single framebuffer pixel-write port between three independent pixel producers (e.g. host SPI slave, fill engine, sprite blitter) using round-robin arbitration with valid/ready handshakes. It clips out-of-screen coordinates and throttles write bursts so that framebuffer-to-panel refresh reads are never starved. Writes suspend refresh reads in the screen controller. The block sits directly in front of the screen controller's `pixel_addr_x` / `pixel_addr_y` / `pixel_wr_en` / `pixel_wr_data` inputs.

## Interface
Parameters:
- `SCREEN_SIZE`, 128 — valid coordinate range is 0..SCREEN_SIZE-1 on both axes.
- `MAX_BURST`, 16 — maximum consecutive write cycles before a forced gap; range 1..255.
- `GAP_CYCLES`, 2 — number of forced idle cycles after a maximal burst; range 1..255.

Ports:
- `clk_main` — in, 1 — single clock for the block.
- `reset` — in, 1 — synchronous, active-high reset.
- `fb_ready` — in, 1 — screen controller is enabled and initialised; writes are allowed only when this is 1.
- `req_valid` — in, 3 — per-requester write request; bit i belongs to requester i.
- `req_x` — in, 24 — 8-bit X coordinate per requester; requester i uses [8i+7:8i].
- `req_y` — in, 24 — 8-bit Y coordinate per requester, packed the same way.
- `req_data` — in, 48 — RGB565 pixel per requester; requester i uses [16i+15:16i].
- `req_ready` — out, 3 — combinational grant; a transfer happens on bit i when `req_valid[i] & req_ready[i]`.
- `pixel_addr_x` — out, 7 — registered write X address.
- `pixel_addr_y` — out, 7 — registered write Y address.
- `pixel_wr_en` — out, 1 — registered one-cycle write strobe.
- `pixel_wr_data` — out, 16 — registered pixel data.
- `grant_id` — out, 2 — index of the last accepted requester.
- `dropped_count` — out, 8 — saturating count of clipped (discarded) transfers.

## Operation
- The FSM has two states: ARB and GAP.
- In ARB with `fb_ready`=1, at most one `req_ready` bit is high.
  - It goes to the first requester with valid high, searching from `last_grant+1` mod 3 upward.
  - `req_ready` depends only on `req_valid`, state, `fb_ready` and registered pointers.
- In GAP, or when `fb_ready`=0, all `req_ready` bits are 0.
- On a transfer from requester i:
  - `last_grant` is set to i and `grant_id` is set to i.
  - If x < SCREEN_SIZE and y < SCREEN_SIZE, the write outputs are loaded: `pixel_addr_x`=x[6:0], `pixel_addr_y`=y[6:0], `pixel_wr_data`=data, and `pixel_wr_en`=1 next cycle.
  - Otherwise the transfer is clipped: it is still accepted, no write is issued, and `dropped_count` increments, saturating at 255.
- `pixel_wr_en` is 1 for exactly one cycle per unclipped transfer and 0 otherwise. Address and data outputs hold their last value when the strobe is low.
- Burst counter (8 bits):
  - Increments on each cycle that issues a write.
  - Clears on any cycle that issues no write (idle, clipped, `fb_ready`=0).
  - When an issuing cycle brings it to MAX_BURST: counter is cleared and the FSM goes to GAP with `gap_cnt`=GAP_CYCLES.
- In GAP, `gap_cnt` decrements every cycle. On the cycle it reaches 0 the FSM returns to ARB, so ready is low for exactly GAP_CYCLES cycles.
- `fb_ready` falling during GAP does not stop the gap countdown.
- Reset values:
  - FSM=ARB, `last_grant`=2 (so requester 0 has first priority).
  - Burst counter, `gap_cnt`, `pixel_addr_x`, `pixel_addr_y`, `pixel_wr_en`, `pixel_wr_data`, `grant_id`, `dropped_count` all 0.
  - `req_ready`=0 while `reset` is high.
- Reset dominates every other event. An in-flight strobe is cancelled: `pixel_wr_en`=0 on the cycle after reset is sampled.

## Timing
- Latency from accepting edge to `pixel_wr_en` high: 1 cycle.
- Throughput: 1 pixel/cycle sustained, except for GAP_CYCLES idle cycles after every MAX_BURST consecutive writes.
- Round robin: with all requesters valid, grants go 0,1,2,0,1,2…; no requester waits more than 2 transfers.
- Requesters must hold `valid`, x, y and data stable until the cycle they are accepted. The arbiter never accepts a requester whose valid is low.

## Test plan
- **Single write.** After reset, requester 1 presents x=5, y=9, data=16'hF800 for one cycle with `fb_ready`=1.
  - Required: `req_ready`=3'b010 that cycle.
  - Next cycle: `pixel_wr_en`=1, (5,9,F800), `grant_id`=1.
- **Round robin.** All three requesters are held valid for 6 cycles.
  - Required: grants 0,1,2,0,1,2 and six one-cycle strobes.
- **Clipping.** Requester 0 presents x=128, y=3, then x=7, y=200.
  - Required: both accepted, no `pixel_wr_en`, `dropped_count`=2.
- **Burst throttle.** MAX_BURST=16, GAP_CYCLES=2, requester 2 valid continuously.
  - Required: 16 strobes, then `req_ready`=0 for exactly 2 cycles, then writes resume. This pattern repeats.
- **fb_ready gating.** `fb_ready`=0 with all requesters valid.
  - Required: `req_ready`=0 and no strobes.
  - When `fb_ready` rises, the first grant goes to requester (`last_grant`+1).
- **Reset mid-operation.** Assert `reset` on the accepting cycle of a write.
  - Required: no strobe follows; all outputs are 0.
  - The next grant goes to requester 0.
